seq_run_tracker: RTL and testbench

- Downstream consumer of the "11" sequence detector's level output `out`, connected here as input `det`.
- Converts each qualified run of `det` high into one event pulse.
- Counts events, measures run lengths and raises a sticky threshold alarm for the status/interrupt logic.
- Filters short runs below MIN_LEN so glitchy detections are not counted.

---
 rtl/seq_run_tracker.sv | 120 ++++++++++++
 tb/tb_seq_run_tracker.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seq_run_tracker.sv
// Run tracker for the "11" detector level output: filters short runs, pulses once
// per qualified run, and keeps run count, run lengths and a sticky threshold alarm.
module seq_run_tracker #(
  parameter int unsigned MIN_LEN = 2,
  parameter int unsigned LW      = 8,
  parameter int unsigned CW      = 8,
  parameter int unsigned THRESH  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          det,
  input  logic          clr,
  output logic          det_pulse,
  output logic [CW-1:0] run_count,
  output logic [LW-1:0] cur_len,
  output logic [LW-1:0] max_len,
  output logic          alarm,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    RUN     = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  localparam logic [LW-1:0] LEN_MAX = '1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state, state_d;
  logic [LW-1:0] cur_len_d, max_len_d, max_base;
  logic [LW:0]   len_inc;
  logic [CW-1:0] count_d;
  logic          pulse_d, alarm_d, qualify, run_exit;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur_len   <= '0;
      max_len   <= '0;
      run_count <= '0;
      det_pulse <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state     <= state_d;
      cur_len   <= cur_len_d;
      max_len   <= max_len_d;
      run_count <= count_d;
      det_pulse <= pulse_d;
      alarm     <= alarm_d;
    end
  end

  assign state_o = state;

  // Next-state, run length and statistics
  always_comb begin
    state_d   = state;
    cur_len_d = cur_len;
    qualify   = 1'b0;
    run_exit  = 1'b0;
    len_inc   = {1'b0, cur_len} + (LW+1)'(1);

    case (state)
      IDLE: begin
        if (det) begin
          cur_len_d = LW'(1);
          if (MIN_LEN == 1) begin
            state_d = RUN;
            qualify = 1'b1;
          end else begin
            state_d = QUAL;
          end
        end
      end
      QUAL: begin
        if (det) begin
          cur_len_d = len_inc[LW-1:0];
          if (32'(len_inc) == MIN_LEN) begin
            state_d = RUN;
            qualify = 1'b1;
          end
        end else begin
          state_d   = IDLE;
          cur_len_d = '0;
        end
      end
      RUN: begin
        if (det) begin
          if (cur_len != LEN_MAX) cur_len_d = len_inc[LW-1:0];
        end else begin
          state_d   = IDLE;
          cur_len_d = '0;
          run_exit  = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        cur_len_d = '0;
      end
    endcase

    // clr zeroes the stats first so a same-cycle qualify or exit lands on top of it
    count_d   = clr ? '0 : run_count;
    alarm_d   = clr ? 1'b0 : alarm;
    max_base  = clr ? '0 : max_len;
    max_len_d = max_base;
    pulse_d   = qualify;

    if (qualify) begin
      if (count_d != CNT_MAX) count_d = count_d + CW'(1);
      if (32'(count_d) >= THRESH) alarm_d = 1'b1;
    end

    if (run_exit && (cur_len > max_base)) max_len_d = cur_len;
  end

endmodule

// File: tb/tb_seq_run_tracker.sv
// Directed bench for seq_run_tracker: default instance plus a narrow LW=3/CW=2 instance.
module tb_seq_run_tracker;

  logic       clk = 1'b0;
  logic       reset, det, clr, det2, clr2;
  logic       det_pulse, alarm, det_pulse2, alarm2;
  logic [7:0] run_count, cur_len, max_len;
  logic [1:0] state_o, state2;
  logic [1:0] run_count2;
  logic [2:0] cur_len2, max_len2;

  int n_vec = 0;
  int n_err = 0;
  int p1 = 0;
  int p2 = 0;

  seq_run_tracker dut (
    .clk(clk), .reset(reset), .det(det), .clr(clr),
    .det_pulse(det_pulse), .run_count(run_count), .cur_len(cur_len),
    .max_len(max_len), .alarm(alarm), .state_o(state_o)
  );

  seq_run_tracker #(.MIN_LEN(2), .LW(3), .CW(2), .THRESH(4)) dut_sat (
    .clk(clk), .reset(reset), .det(det2), .clr(clr2),
    .det_pulse(det_pulse2), .run_count(run_count2), .cur_len(cur_len2),
    .max_len(max_len2), .alarm(alarm2), .state_o(state2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (det_pulse) p1++;
    if (det_pulse2) p2++;
  endtask

  task automatic run_len(input int n);
    det = 1'b1;
    repeat (n) tick();
    det = 1'b0;
    tick();
  endtask

  task automatic all_zero(input string tag);
    chk(tag, 32'({det_pulse, run_count, cur_len, max_len, alarm, state_o}), 32'd0);
  endtask

  initial begin
    reset = 1'b1; det = 1'b0; clr = 1'b0; det2 = 1'b0; clr2 = 1'b0;

    // reset and idle
    repeat (3) begin
      tick();
      all_zero("in_reset");
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      all_zero("idle");
    end

    // short-run filter, then a 5-cycle run
    det = 1'b1; tick();
    chk("qual_state", 32'(state_o), 32'd1);
    chk("qual_len", 32'(cur_len), 32'd1);
    det = 1'b0; tick(); tick();
    chk("filt_pulses", 32'(p1), 32'd0);
    chk("filt_count", 32'(run_count), 32'd0);
    chk("filt_max", 32'(max_len), 32'd0);
    det = 1'b1;
    tick();
    chk("r5_e1_pulse", 32'(det_pulse), 32'd0);
    tick();
    chk("r5_e2_pulse", 32'(det_pulse), 32'd1);
    chk("r5_count", 32'(run_count), 32'd1);
    chk("r5_state", 32'(state_o), 32'd2);
    repeat (3) tick();
    chk("r5_len", 32'(cur_len), 32'd5);
    det = 1'b0; tick();
    chk("r5_pulses", 32'(p1), 32'd1);
    chk("r5_max", 32'(max_len), 32'd5);
    chk("r5_cur0", 32'(cur_len), 32'd0);

    // alarm at threshold
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_count", 32'(run_count), 32'd0);
    chk("clr_max", 32'(max_len), 32'd0);
    run_len(3); run_len(4); run_len(2);
    chk("a3_count", 32'(run_count), 32'd3);
    chk("a3_alarm", 32'(alarm), 32'd0);
    chk("a3_max", 32'(max_len), 32'd4);
    det = 1'b1; tick();
    chk("a4_pre_alarm", 32'(alarm), 32'd0);
    tick();
    chk("a4_pulse", 32'(det_pulse), 32'd1);
    chk("a4_count", 32'(run_count), 32'd4);
    chk("a4_alarm", 32'(alarm), 32'd1);
    repeat (4) tick();
    det = 1'b0; tick();
    chk("a4_max", 32'(max_len), 32'd6);
    chk("a4_alarm_hold", 32'(alarm), 32'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr2_count", 32'(run_count), 32'd0);
    chk("clr2_alarm", 32'(alarm), 32'd0);
    chk("clr2_max", 32'(max_len), 32'd0);

    // clr coincident with qualify, then with a run exit
    run_len(2); run_len(2); run_len(2);
    chk("s_count3", 32'(run_count), 32'd3);
    det = 1'b1; tick();
    clr = 1'b1; tick(); clr = 1'b0;
    chk("s_pulse", 32'(det_pulse), 32'd1);
    chk("s_count", 32'(run_count), 32'd1);
    chk("s_alarm", 32'(alarm), 32'd0);
    det = 1'b0; tick();
    chk("s_pulse_off", 32'(det_pulse), 32'd0);
    chk("s_max2", 32'(max_len), 32'd2);
    run_len(5);
    chk("s_max5", 32'(max_len), 32'd5);
    det = 1'b1; repeat (3) tick();
    det = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    chk("sx_max", 32'(max_len), 32'd3);
    chk("sx_count", 32'(run_count), 32'd0);
    chk("sx_state", 32'(state_o), 32'd0);

    // saturation on the narrow instance
    p2 = 0;
    det2 = 1'b1; repeat (12) tick();
    chk("sat_cur", 32'(cur_len2), 32'd7);
    chk("sat_state", 32'(state2), 32'd2);
    det2 = 1'b0; tick();
    chk("sat_max", 32'(max_len2), 32'd7);
    chk("sat_cur0", 32'(cur_len2), 32'd0);
    repeat (4) begin
      det2 = 1'b1; tick(); tick();
      det2 = 1'b0; tick();
    end
    chk("sat_pulses", 32'(p2), 32'd5);
    chk("sat_count", 32'(run_count2), 32'd3);
    chk("sat_alarm", 32'(alarm2), 32'd0);

    // asynchronous reset mid-run
    det = 1'b1; repeat (4) tick();
    chk("ar_len", 32'(cur_len), 32'd4);
    chk("ar_state", 32'(state_o), 32'd2);
    #2 reset = 1'b1;
    #1 all_zero("ar_async");
    #1 reset = 1'b0;
    p1 = 0;
    tick();
    chk("ar_q_state", 32'(state_o), 32'd1);
    chk("ar_q_pulse", 32'(det_pulse), 32'd0);
    tick();
    chk("ar_pulse", 32'(det_pulse), 32'd1);
    chk("ar_count", 32'(run_count), 32'd1);
    det = 1'b0; tick();
    chk("ar_max", 32'(max_len), 32'd2);
    chk("ar_pulses", 32'(p1), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
